loop_update_queue: RTL

- Buffers branch-resolution updates from the backend and issues them, one per cycle, to the loop branch predictor bank's io_update_* inputs.
- The bank has no backpressure, so this block holds the flow control: valid/ready on enqueue, a hold input on the drain side, and flush.
- Drops updates the bank would ignore, so no FIFO slots are wasted.
- Issue order to the bank matches accept order.

---
 rtl/loop_update_queue_if.sv | 44 ++++
 rtl/loop_update_queue.sv | 129 ++++++++++++
 2 files changed

// File: rtl/loop_update_queue_if.sv
// Enqueue and bank-update bundle for loop_update_queue.
// master = backend side (drives enq, observes update); slave = the queue.
interface loop_update_queue_if #(
  parameter int PC_W   = 40,
  parameter int META_W = 120,
  parameter int NCOL   = 4
);
  logic              io_enq_valid;
  logic              io_enq_ready;
  logic [PC_W-1:0]   io_enq_bits_pc;
  logic [NCOL-1:0]   io_enq_bits_br_mask;
  logic              io_enq_bits_is_mispredict_update;
  logic              io_enq_bits_is_repair_update;
  logic              io_enq_bits_cfi_mispredicted;
  logic [META_W-1:0] io_enq_bits_meta;

  logic              io_update_valid;
  logic [PC_W-1:0]   io_update_bits_pc;
  logic [NCOL-1:0]   io_update_bits_br_mask;
  logic              io_update_bits_is_mispredict_update;
  logic              io_update_bits_is_repair_update;
  logic              io_update_bits_cfi_mispredicted;
  logic [META_W-1:0] io_update_bits_meta;

  modport master (
    output io_enq_valid, io_enq_bits_pc, io_enq_bits_br_mask,
           io_enq_bits_is_mispredict_update, io_enq_bits_is_repair_update,
           io_enq_bits_cfi_mispredicted, io_enq_bits_meta,
    input  io_enq_ready,
    input  io_update_valid, io_update_bits_pc, io_update_bits_br_mask,
           io_update_bits_is_mispredict_update, io_update_bits_is_repair_update,
           io_update_bits_cfi_mispredicted, io_update_bits_meta
  );

  modport slave (
    input  io_enq_valid, io_enq_bits_pc, io_enq_bits_br_mask,
           io_enq_bits_is_mispredict_update, io_enq_bits_is_repair_update,
           io_enq_bits_cfi_mispredicted, io_enq_bits_meta,
    output io_enq_ready,
    output io_update_valid, io_update_bits_pc, io_update_bits_br_mask,
           io_update_bits_is_mispredict_update, io_update_bits_is_repair_update,
           io_update_bits_cfi_mispredicted, io_update_bits_meta
  );
endinterface

// File: rtl/loop_update_queue.sv
// loop_update_queue: buffers qualifying branch-resolution updates and issues
// them one per cycle, in accept order, to the loop predictor bank.
// Optional: define LOOP_UPDQ_COALESCE_EN to merge a matching update into the
// tail entry instead of allocating a new slot.
module loop_update_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 40,
  parameter int META_W = 120,
  parameter int NCOL   = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_deq_hold,
  input  logic                         io_flush,
  output logic [$clog2(DEPTH+1)-1:0]   io_count,
  loop_update_queue_if.slave           io
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int COL_W = 10;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [NCOL-1:0]   br_mask;
    logic              misp;
    logic              repair;
    logic              cfi;
    logic [META_W-1:0] meta;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  entry_t             out_q, out_d, enq_e;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               vld_q, vld_d;
  logic               enq_ready, accept, qual, empty, pop, bypass, merge, alloc;

  assign enq_e = '{pc:      io.io_enq_bits_pc,
                   br_mask: io.io_enq_bits_br_mask,
                   misp:    io.io_enq_bits_is_mispredict_update,
                   repair:  io.io_enq_bits_is_repair_update,
                   cfi:     io.io_enq_bits_cfi_mispredicted,
                   meta:    io.io_enq_bits_meta};

  // Handshake and qualification; ready depends only on the registered count.
  always_comb begin
    enq_ready = (count_q < CNT_W'(DEPTH));
    accept    = io.io_enq_valid & enq_ready;
    qual      = accept & (|enq_e.br_mask) & (enq_e.repair | (enq_e.misp & enq_e.cfi));
    empty     = (count_q == '0);
    pop       = ~empty & ~io_deq_hold & ~io_flush;
    // Empty queue and free drain: the new entry goes straight to the output.
    bypass    = empty & qual & ~io_deq_hold & ~io_flush;
  end

`ifdef LOOP_UPDQ_COALESCE_EN
  logic [PTR_W-1:0] tail_ptr;
  entry_t           tail_e, merged_e;

  // Merge into the tail when it stays resident and describes the same packet.
  always_comb begin
    tail_ptr = wr_ptr_q - PTR_W'(1);
    tail_e   = mem_q[tail_ptr];
    merge    = qual & ~empty & ~io_flush & ~(pop & (count_q == CNT_W'(1))) &
               (tail_e.pc[PC_W-1:4] == enq_e.pc[PC_W-1:4]) &
               (tail_e.misp == enq_e.misp) & (tail_e.repair == enq_e.repair) &
               (tail_e.cfi == enq_e.cfi);
    merged_e         = tail_e;
    merged_e.br_mask = tail_e.br_mask | enq_e.br_mask;
    for (int i = 0; i < NCOL; i++)
      if (enq_e.br_mask[i])
        merged_e.meta[COL_W*i +: COL_W] = enq_e.meta[COL_W*i +: COL_W];
  end
`else
  always_comb merge = 1'b0;
`endif

  // Storage, pointer, count and output-register next state.
  always_comb begin
    alloc    = qual & ~io_flush & ~bypass & ~merge;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(alloc);
    count_d  = count_q + CNT_W'(alloc) - CNT_W'(pop);
    if (alloc) mem_d[wr_ptr_q] = enq_e;
`ifdef LOOP_UPDQ_COALESCE_EN
    if (merge) mem_d[tail_ptr] = merged_e;
`endif
    if (io_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    vld_d = pop | bypass;
    out_d = out_q;
    if (pop)         out_d = mem_q[rd_ptr_q];
    else if (bypass) out_d = enq_e;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      vld_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      vld_q    <= vld_d;
      out_q    <= out_d;
    end
  end

  assign io_count                               = count_q;
  assign io.io_enq_ready                        = enq_ready;
  assign io.io_update_valid                     = vld_q;
  assign io.io_update_bits_pc                   = out_q.pc;
  assign io.io_update_bits_br_mask              = out_q.br_mask;
  assign io.io_update_bits_is_mispredict_update = out_q.misp;
  assign io.io_update_bits_is_repair_update     = out_q.repair;
  assign io.io_update_bits_cfi_mispredicted     = out_q.cfi;
  assign io.io_update_bits_meta                 = out_q.meta;
endmodule
